// File: rtl/ps2_pkg.sv
// Shared PS/2 frame layout constants and well-known scan-code prefixes.
package ps2_pkg;

   localparam int PS2_FRAME_BITS = 11;

   localparam int START  = 0;
   localparam int PARITY = 9;
   localparam int STOP   = 10;

   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXTEND = 8'hE0;

endpackage

// File: rtl/ps2_byte_fifo.sv
// Small registered byte FIFO with wrap-bit pointers; head byte shown combinationally.
module ps2_byte_fifo #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [7:0]  mem_d [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        do_push;
   logic        do_pop;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign dout  = mem_q[rd_ptr_q[AW-1:0]];

   // A pop frees a slot in the same cycle, so a full FIFO may still accept a push.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = din;
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronise, collect 11-bit frames, check them, buffer bytes.
module ps2_kbd_rx
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       nextdata_n,
   output logic [7:0] data,
   output logic       ready,
   output logic       overflow,
   output logic       frame_err
);

   localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

   logic [2:0]                clk_sync_q, clk_sync_d;
   logic [1:0]                dat_sync_q, dat_sync_d;
   logic [PS2_FRAME_BITS-1:0] shift_q, shift_d;
   logic [3:0]                count_q, count_d;
   logic [TW-1:0]             to_q, to_d;
   logic                      overflow_q, overflow_d;
   logic                      frame_err_q, frame_err_d;

   logic                      fall;
   logic                      bit_in;
   logic [PS2_FRAME_BITS-1:0] frame;
   logic                      frame_ok;
   logic                      push;
   logic                      pop;
   logic                      empty;
   logic                      full;

   // Data takes two flops so it lines up with the clock sample used for the edge.
   assign fall   = clk_sync_q[2] & ~clk_sync_q[1];
   assign bit_in = dat_sync_q[1];

   // The frame as it will look once the current bit is shifted in.
   assign frame    = {bit_in, shift_q[PS2_FRAME_BITS-1:1]};
   assign frame_ok = ~frame[START] & frame[STOP] & (^frame[8:1] ^ frame[PARITY]);

   assign pop = ~nextdata_n & ready;

   always_comb begin
      clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
      dat_sync_d  = {dat_sync_q[0], ps2_data};
      shift_d     = shift_q;
      count_d     = count_q;
      to_d        = '0;
      push        = 1'b0;
      frame_err_d = 1'b0;
      if (fall) begin
         shift_d = frame;
         if (count_q == 4'(STOP)) begin
            count_d     = 4'd0;
            push        = frame_ok;
            frame_err_d = ~frame_ok;
         end else begin
            count_d = count_q + 4'd1;
         end
      end else if (count_q != 4'd0) begin
         // A stalled partial frame is abandoned without flagging an error.
         if (to_q == TO_MAX) begin
            count_d = 4'd0;
         end else begin
            to_d = to_q + 1'b1;
         end
      end
      overflow_d = overflow_q | (push & full & ~pop);
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         clk_sync_q  <= 3'b111;
         dat_sync_q  <= 2'b11;
         shift_q     <= '0;
         count_q     <= 4'd0;
         to_q        <= '0;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         clk_sync_q  <= clk_sync_d;
         dat_sync_q  <= dat_sync_d;
         shift_q     <= shift_d;
         count_q     <= count_d;
         to_q        <= to_d;
         overflow_q  <= overflow_d;
         frame_err_q <= frame_err_d;
      end
   end

   ps2_byte_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk  (clk),
      .rst_n(clrn),
      .push (push),
      .din  (frame[8:1]),
      .pop  (pop),
      .dout (data),
      .empty(empty),
      .full (full)
   );

   assign ready     = ~empty;
   assign overflow  = overflow_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: drives PS/2 frames bit by bit and checks FIFO outputs.
module tb_ps2_kbd_rx;

   localparam int FIFO_DEPTH     = 8;
   localparam int TIMEOUT_CYCLES = 200;

   logic       clk;
   logic       clrn;
   logic       ps2_clk;
   logic       ps2_data;
   logic       nextdata_n;
   logic [7:0] data;
   logic       ready;
   logic       overflow;
   logic       frame_err;

   int total;
   int bad;
   int err_cycles;

   ps2_kbd_rx #(
      .FIFO_DEPTH    (FIFO_DEPTH),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk       (clk),
      .clrn      (clrn),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .nextdata_n(nextdata_n),
      .data      (data),
      .ready     (ready),
      .overflow  (overflow),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_err === 1'b1) err_cycles++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic ps2_bit(input logic b);
      @(negedge clk);
      ps2_data = b;
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (20) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   // mode 0: plain, 1: check ready latency at the stop edge, 2: pop on the push edge
   task automatic send_frame(input logic [7:0] b, input logic bad_par, input int mode);
      logic par;
      par = ~^b ^ bad_par;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(par);
      @(negedge clk);
      ps2_data = 1'b1;
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      if (mode == 1) check("ready_before_3rd_edge", {31'd0, ready}, 32'd0);
      if (mode == 2) begin
         @(negedge clk);
         nextdata_n = 1'b0;
      end
      @(posedge clk);
      #1;
      if (mode == 1) check("ready_at_3rd_edge", {31'd0, ready}, 32'd1);
      @(negedge clk);
      nextdata_n = 1'b1;
      repeat (18) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic pop_one();
      @(negedge clk);
      nextdata_n = 1'b0;
      @(negedge clk);
      nextdata_n = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clrn = 1'b0;
      repeat (3) @(negedge clk);
      clrn = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      err_cycles = 0;
      clrn       = 1'b0;
      ps2_clk    = 1'b1;
      ps2_data   = 1'b1;
      nextdata_n = 1'b1;

      repeat (3) @(negedge clk);
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_data", {24'd0, data}, 32'h00);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      check("rst_frame_err", {31'd0, frame_err}, 32'd0);
      clrn = 1'b1;
      repeat (3) @(negedge clk);

      // single byte with latency check
      err_cycles = 0;
      send_frame(8'h1C, 1'b0, 1);
      check("1c_data", {24'd0, data}, 32'h1C);
      check("1c_hi_nibble", {28'd0, data[7:4]}, 32'h1);
      check("1c_lo_nibble", {28'd0, data[3:0]}, 32'hC);
      check("1c_no_err", err_cycles, 32'd0);
      pop_one();
      check("1c_popped_ready", {31'd0, ready}, 32'd0);

      // two bytes queued
      send_frame(8'hF0, 1'b0, 0);
      send_frame(8'h1C, 1'b0, 0);
      check("q_first", {24'd0, data}, 32'hF0);
      pop_one();
      check("q_second", {24'd0, data}, 32'h1C);
      check("q_second_ready", {31'd0, ready}, 32'd1);
      pop_one();
      check("q_empty", {31'd0, ready}, 32'd0);

      // bad parity then good frame
      err_cycles = 0;
      send_frame(8'h1C, 1'b1, 0);
      check("par_err_cycles", err_cycles, 32'd1);
      check("par_ready", {31'd0, ready}, 32'd0);
      send_frame(8'h32, 1'b0, 0);
      check("after_err_data", {24'd0, data}, 32'h32);
      check("after_err_cycles", err_cycles, 32'd1);
      pop_one();

      // overflow: nine bytes into an eight-deep FIFO
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 0);
      check("ovf_set", {31'd0, overflow}, 32'd1);
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("ovf_pop_%0d", i), {24'd0, data}, 32'(i));
         pop_one();
      end
      check("ovf_drained", {31'd0, ready}, 32'd0);
      check("ovf_sticky", {31'd0, overflow}, 32'd1);

      // simultaneous push and pop while full
      do_reset();
      check("reset_clears_ovf", {31'd0, overflow}, 32'd0);
      for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 0);
      send_frame(8'h09, 1'b0, 2);
      check("pp_no_ovf", {31'd0, overflow}, 32'd0);
      for (int i = 2; i <= 9; i++) begin
         check($sformatf("pp_pop_%0d", i), {24'd0, data}, 32'(i));
         pop_one();
      end
      check("pp_drained", {31'd0, ready}, 32'd0);

      // timeout of a partial frame
      err_cycles = 0;
      for (int i = 0; i < 5; i++) ps2_bit(1'b0);
      repeat (TIMEOUT_CYCLES + 10) @(negedge clk);
      send_frame(8'h45, 1'b0, 0);
      check("to_data", {24'd0, data}, 32'h45);
      check("to_no_err", err_cycles, 32'd0);
      pop_one();

      // reset in the middle of a frame
      send_frame(8'h11, 1'b0, 0);
      check("mid_pre_ready", {31'd0, ready}, 32'd1);
      for (int i = 0; i < 6; i++) ps2_bit(1'b0);
      @(negedge clk);
      clrn = 1'b0;
      #1;
      check("mid_rst_ready", {31'd0, ready}, 32'd0);
      check("mid_rst_data", {24'd0, data}, 32'h00);
      check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
      check("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
      repeat (3) @(negedge clk);
      clrn = 1'b1;
      err_cycles = 0;
      send_frame(8'h5A, 1'b0, 0);
      check("mid_next_data", {24'd0, data}, 32'h5A);
      check("mid_next_ready", {31'd0, ready}, 32'd1);
      check("mid_next_no_err", err_cycles, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
